// File: rtl/div_unit.sv
// Multicycle signed restoring divider for MIPS DIV: quotient to lo, remainder to hi.
// One quotient bit per clock on operand magnitudes, then a single sign-fixup cycle.
//
// state  | meaning
// IDLE   | waiting for start; results held
// CALC   | one restoring-division step per edge, WIDTH edges
// FIX    | apply signs and load hi/lo
// DONE   | done pulse for one cycle, back to IDLE
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dq_q, dq_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             dz_q, dz_d;
  logic [WIDTH:0]   trial;

  // Shifted partial remainder minus divisor; the extra bit is the borrow/sign.
  assign trial = {rem_q, dq_q[WIDTH-1]} - {1'b0, dvs_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dq_d    = dq_q;
    dvs_d   = dvs_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dz_d    = dz_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (b == '0) begin
            dz_d    = 1'b1;
            state_d = S_DONE;
          end else begin
            // Negating 0x80..0 wraps back to itself, which is the correct unsigned magnitude.
            dq_d    = a[WIDTH-1] ? -a : a;
            dvs_d   = b[WIDTH-1] ? -b : b;
            qneg_d  = a[WIDTH-1] ^ b[WIDTH-1];
            rneg_d  = a[WIDTH-1];
            rem_d   = '0;
            cnt_d   = CW'(WIDTH);
            dz_d    = 1'b0;
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (!trial[WIDTH]) begin
          rem_d = trial[WIDTH-1:0];
          dq_d  = {dq_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = {rem_q[WIDTH-2:0], dq_q[WIDTH-1]};
          dq_d  = {dq_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_FIX;
      end
      S_FIX: begin
        lo_d    = qneg_q ? -dq_q : dq_q;
        hi_d    = rneg_q ? -rem_q : rem_q;
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dq_q    <= '0;
      dvs_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dq_q    <= dq_d;
      dvs_q   <= dvs_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dz_q    <= dz_d;
    end
  end

  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_zero = dz_q;
  assign busy     = (state_q == S_CALC) || (state_q == S_FIX);
  assign done     = (state_q == S_DONE);

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: scoreboard of expected hi/lo/div_zero per start,
// plus latency, busy/done handshake, ignored-start and async-reset checks.
module tb_div_unit;
  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] a, b;
  logic [31:0] hi, lo;
  logic        busy, done, div_zero;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        dz;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] mlo = '0, mhi = '0;

  div_unit #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset), .start(start), .a(a), .b(b),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // MIPS reference: truncating quotient, remainder with dividend's sign.
  function automatic exp_t model(input logic [31:0] av, input logic [31:0] bv);
    exp_t        e;
    logic [31:0] ma, mb, uq, ur;
    if (bv == 32'd0) begin
      e.lo = mlo; e.hi = mhi; e.dz = 1'b1;
    end else begin
      ma = av[31] ? (32'd0 - av) : av;
      mb = bv[31] ? (32'd0 - bv) : bv;
      uq = ma / mb;
      ur = ma % mb;
      e.lo = (av[31] ^ bv[31]) ? (32'd0 - uq) : uq;
      e.hi = av[31] ? (32'd0 - ur) : ur;
      e.dz = 1'b0;
      mlo = e.lo; mhi = e.hi;
    end
    return e;
  endfunction

  task automatic run(input logic [31:0] av, input logic [31:0] bv, input int exp_lat, input int inject_at);
    int   n;
    int   busy_n;
    exp_t e;
    a = av; b = bv; start = 1'b1;
    sb.push_back(model(av, bv));
    step();
    start = 1'b0;
    n = 0; busy_n = 0;
    while (!done && n < 100) begin
      if (busy) busy_n++;
      if (n == inject_at) begin
        a = 32'd1; b = 32'd1; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      step();
      n++;
    end
    start = 1'b0;
    chk("latency", 32'(n), 32'(exp_lat));
    chk("busy_cycles", 32'(busy_n), 32'(exp_lat));
    if (done) begin
      chk("busy_with_done", {31'd0, busy}, 32'd0);
      e = sb.pop_front();
      chk("lo", lo, e.lo);
      chk("hi", hi, e.hi);
      chk("div_zero", {31'd0, div_zero}, {31'd0, e.dz});
    end
    step();
    chk("done_pulse_end", {31'd0, done}, 32'd0);
  endtask

  initial begin
    int dn;
    reset = 1'b1; start = 1'b0; a = '0; b = '0;
    step(); step();
    chk("rst_lo", lo, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_dz", {31'd0, div_zero}, 32'd0);
    reset = 1'b0;
    step();

    run(32'd100, 32'd7, 33, -1);
    chk("d100_7_lo", lo, 32'h0000_000E);
    chk("d100_7_hi", hi, 32'h0000_0002);

    run(32'hFFFF_FFF9, 32'd2, 33, -1);
    chk("dm7_2_lo", lo, 32'hFFFF_FFFD);
    chk("dm7_2_hi", hi, 32'hFFFF_FFFF);
    run(32'd7, 32'hFFFF_FFFE, 33, -1);
    chk("d7_m2_lo", lo, 32'hFFFF_FFFD);
    chk("d7_m2_hi", hi, 32'h0000_0001);

    run(32'h8000_0000, 32'hFFFF_FFFF, 33, -1);
    chk("ovf_lo", lo, 32'h8000_0000);
    chk("ovf_hi", hi, 32'h0000_0000);
    run(32'd5, 32'd0, 0, -1);
    chk("dz_flag", {31'd0, div_zero}, 32'd1);
    chk("dz_lo_held", lo, 32'h8000_0000);

    // second start mid-CALC with new operands must be ignored
    run(32'd100, 32'd7, 33, 10);
    chk("ign_lo", lo, 32'h0000_000E);
    chk("ign_hi", hi, 32'h0000_0002);

    // async reset in the middle of a division
    a = 32'd100; b = 32'd7; start = 1'b1;
    step();
    start = 1'b0;
    repeat (14) step();
    #2 reset = 1'b1;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_dz", {31'd0, div_zero}, 32'd0);
    chk("arst_lo", lo, 32'd0);
    chk("arst_hi", hi, 32'd0);
    mlo = '0; mhi = '0;
    step();
    reset = 1'b0;
    dn = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (done) dn++;
    end
    chk("arst_no_done", 32'(dn), 32'd0);
    run(32'd9, 32'd3, 33, -1);
    chk("d9_3_lo", lo, 32'd3);

    // back-to-back: zero divide, then next start right after done
    run(32'd11, 32'd0, 0, -1);
    run(32'd20, 32'hFFFF_FFFD, 33, -1);
    chk("b2b_dz_clear", {31'd0, div_zero}, 32'd0);
    chk("b2b_lo", lo, 32'hFFFF_FFFA);
    run(32'd0, 32'd5, 33, -1);
    run(32'hFFFF_FF9C, 32'd1, 33, -1);
    run(32'hFFFF_FFFD, 32'd10, 33, -1);
    chk("small_hi", hi, 32'hFFFF_FFFD);
    run(32'h7FFF_FFFF, 32'h8000_0000, 33, -1);
    run(32'h1234_5678, 32'hFFFF_F00D, 33, -1);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
